// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Holds the FSM encoding, default bus widths and requester port indices.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // One-hot select for a port index, bit 0 = core, bit 1 = loader.
    function automatic logic [1:0] port_onehot(input logic idx);
        port_onehot = (idx == PORT_LOAD) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant: purely combinational, one-hot or zero output.
// On a tie the port not named by last wins; the caller owns the last-grant state.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core and a loader/debug requester.
// Latency: accept at edge T, memory access in T+1, response pulse in T+2; ready only while idle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                cmd_we_q, cmd_we_d;
    logic                cmd_port_q, cmd_port_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                accept;
    logic [DATA_W-1:0]   rsp_data;

    assign req = {p1_valid, p0_valid};

    rr_arbiter2 u_rr (
        .req  (req),
        .last (last_grant_q),
        .gnt  (gnt)
    );

    assign accept = (state_q == IDLE) && (gnt != 2'b00);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; handshakes are forced low while reset is held so nothing leaks mid-reset.
    always_comb begin
        p0_ready     = 1'b0;
        p1_ready     = 1'b0;
        p0_rsp_valid = 1'b0;
        p1_rsp_valid = 1'b0;
        mem_we       = 1'b0;
        busy         = 1'b0;
        if (rst_n) begin
            busy = (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    p0_ready = gnt[0];
                    p1_ready = gnt[1];
                end
                ACCESS: begin
                    mem_we = cmd_we_q;
                end
                RESP: begin
                    {p1_rsp_valid, p0_rsp_valid} = port_onehot(cmd_port_q);
                end
                default: ;
            endcase
        end
    end

    // Address/data follow the latched command, so they naturally hold between accesses.
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    assign rsp_data = cmd_we_q ? '0 : mem_rdata;

    always_comb begin
        last_grant_d = last_grant_q;
        cmd_we_d     = cmd_we_q;
        cmd_port_d   = cmd_port_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;

        if (accept) begin
            cmd_port_d = gnt[1] ? PORT_LOAD : PORT_CORE;
            if (gnt[1]) begin
                cmd_we_d    = p1_we;
                cmd_addr_d  = p1_addr;
                cmd_wdata_d = p1_wdata;
            end else begin
                cmd_we_d    = p0_we;
                cmd_addr_d  = p0_addr;
                cmd_wdata_d = p0_wdata;
            end
            // Round-robin history only advances when both ports contended.
            if (req == 2'b11) begin
                last_grant_d = gnt[1];
            end
        end

        // Each port keeps its own response register so the idle port's rdata holds.
        if (state_q == ACCESS) begin
            if (cmd_port_q == PORT_LOAD) begin
                p1_rdata_d = rsp_data;
            end else begin
                p0_rdata_d = rsp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            cmd_we_q     <= 1'b0;
            cmd_port_q   <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            cmd_we_q     <= cmd_we_d;
            cmd_port_q   <= cmd_port_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: hand-computed expectations checked with immediate assertions.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_valid, p0_ready, p0_we, p0_rsp_valid;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_valid, p1_ready, p1_we, p1_rsp_valid;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .p0_valid     (p0_valid),
        .p0_ready     (p0_ready),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rdata     (p0_rdata),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rdata     (p1_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 2ns after the next rising edge; callers drive inputs, then settle() before checking.
    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, ".p0_ready"}, 32'(p0_ready), 32'd0);
        chk({tag, ".p1_ready"}, 32'(p1_ready), 32'd0);
        chk({tag, ".p0_rsp"}, 32'(p0_rsp_valid), 32'd0);
        chk({tag, ".p1_rsp"}, 32'(p1_rsp_valid), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_quiet(tag);
        chk({tag, ".mem_addr"}, mem_addr, 32'd0);
        chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, ".p0_rdata"}, p0_rdata, 32'd0);
        chk({tag, ".p1_rdata"}, p1_rdata, 32'd0);
    endtask

    initial begin : stim
        int rsp_cyc [4];
        logic [1:0] order [4];
        rst_n = 1'b0;
        p0_valid = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_valid = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        mem_rdata = 32'h0;

        // Reset
        tick(); tick();
        settle();
        chk_all_zero("reset_held");
        rst_n = 1'b1;
        tick(); settle();
        chk_all_zero("reset_released");

        // Single read on p0
        p0_valid = 1; p0_we = 0; p0_addr = 32'h10;
        settle();
        chk("rd.p0_ready", 32'(p0_ready), 32'd1);
        chk("rd.p1_ready", 32'(p1_ready), 32'd0);
        tick();
        p0_valid = 0; mem_rdata = 32'hDEADBEEF;
        settle();
        chk("rd.mem_we", 32'(mem_we), 32'd0);
        chk("rd.mem_addr", mem_addr, 32'h10);
        chk("rd.busy", 32'(busy), 32'd1);
        chk("rd.ready_in_access", 32'(p0_ready), 32'd0);
        tick(); settle();
        chk("rd.p0_rsp", 32'(p0_rsp_valid), 32'd1);
        chk("rd.p0_rdata", p0_rdata, 32'hDEADBEEF);
        chk("rd.p1_rsp", 32'(p1_rsp_valid), 32'd0);
        chk("rd.p1_rdata", p1_rdata, 32'd0);
        tick(); settle();
        chk("rd.p0_rsp_drop", 32'(p0_rsp_valid), 32'd0);
        chk("rd.p0_rdata_hold", p0_rdata, 32'hDEADBEEF);
        chk("rd.busy_idle", 32'(busy), 32'd0);

        // Single write on p1
        p1_valid = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678;
        settle();
        chk("wr.p1_ready", 32'(p1_ready), 32'd1);
        chk("wr.mem_we_idle", 32'(mem_we), 32'd0);
        tick();
        p1_valid = 0; mem_rdata = 32'hCAFEF00D;
        settle();
        chk("wr.mem_we", 32'(mem_we), 32'd1);
        chk("wr.mem_addr", mem_addr, 32'h20);
        chk("wr.mem_wdata", mem_wdata, 32'h12345678);
        tick(); settle();
        chk("wr.mem_we_resp", 32'(mem_we), 32'd0);
        chk("wr.mem_addr_hold", mem_addr, 32'h20);
        chk("wr.p1_rsp", 32'(p1_rsp_valid), 32'd1);
        chk("wr.p1_rdata", p1_rdata, 32'd0);
        chk("wr.p0_rsp", 32'(p0_rsp_valid), 32'd0);
        chk("wr.p0_rdata_hold", p0_rdata, 32'hDEADBEEF);
        tick(); settle();
        chk("wr.mem_we_after", 32'(mem_we), 32'd0);
        chk("wr.p1_rsp_drop", 32'(p1_rsp_valid), 32'd0);

        // Tie after reset: p0, p1, p0, p1
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
        p0_valid = 1; p0_we = 0; p0_addr = 32'h100;
        p1_valid = 1; p1_we = 0; p1_addr = 32'h200;
        mem_rdata = 32'h0000AAAA;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("tie%0d.ready", i), 32'({p1_ready, p0_ready}), 32'(order[i]));
            tick(); settle();
            chk($sformatf("tie%0d.addr", i), mem_addr, order[i][1] ? 32'h200 : 32'h100);
            tick(); settle();
            chk($sformatf("tie%0d.rsp", i), 32'({p1_rsp_valid, p0_rsp_valid}), 32'(order[i]));
            rsp_cyc[i] = cyc;
            if (i > 0) chk($sformatf("tie%0d.spacing", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
            tick();
        end
        p0_valid = 0; p1_valid = 0;
        tick();

        // Backpressure: p1 arrives during p0's access
        p0_valid = 1; p0_we = 0; p0_addr = 32'h30;
        settle();
        chk("bp.p0_ready", 32'(p0_ready), 32'd1);
        tick();
        p0_valid = 0;
        p1_valid = 1; p1_we = 1; p1_addr = 32'h40; p1_wdata = 32'hA5A5_5A5A;
        mem_rdata = 32'h0BAD_F00D;
        settle();
        chk("bp.p1_ready_access", 32'(p1_ready), 32'd0);
        tick(); settle();
        chk("bp.p1_ready_resp", 32'(p1_ready), 32'd0);
        chk("bp.p0_rdata", p0_rdata, 32'h0BAD_F00D);
        tick(); settle();
        chk("bp.p1_ready_idle", 32'(p1_ready), 32'd1);
        tick();
        p1_valid = 0;
        settle();
        chk("bp.mem_we", 32'(mem_we), 32'd1);
        chk("bp.mem_addr", mem_addr, 32'h40);
        chk("bp.mem_wdata", mem_wdata, 32'hA5A5_5A5A);
        tick(); settle();
        chk("bp.p1_rsp", 32'(p1_rsp_valid), 32'd1);
        chk("bp.p1_rdata", p1_rdata, 32'd0);
        tick();

        // Reset in the ACCESS cycle of a write
        p1_valid = 1; p1_we = 1; p1_addr = 32'h50; p1_wdata = 32'h77;
        settle();
        chk("mid.p1_ready", 32'(p1_ready), 32'd1);
        tick();
        p1_valid = 0; rst_n = 0;
        settle();
        chk("mid.mem_we_in_reset", 32'(mem_we), 32'd0);
        tick(); settle();
        chk_all_zero("mid.after_edge");
        rst_n = 1;
        tick(); settle();
        chk_all_zero("mid.released");
        tick(); settle();
        chk_all_zero("mid.released2");
        p0_valid = 1; p0_addr = 32'h60; p1_valid = 1; p1_addr = 32'h70;
        settle();
        chk("mid.tie_ready", 32'({p1_ready, p0_ready}), 32'b01);
        tick();
        p0_valid = 0; p1_valid = 0;
        tick(); tick(); tick();

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            settle();
            chk_quiet($sformatf("idle%0d", i));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters, one per line:
- ADDR_W, 32, address width
- DATA_W, 32, data width
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- p0_valid  in  1  port 0 (core load/store) request valid
- p0_ready  out  1  port 0 request accepted this cycle
- p0_we  in  1  port 0 write (1) / read (0)
- p0_addr  in  ADDR_W  port 0 byte address
- p0_wdata  in  DATA_W  port 0 write data
- p0_rsp_valid  out  1  port 0 response pulse
- p0_rdata  out  DATA_W  port 0 read data
- p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rsp_valid, p1_rdata: same as p0_*, for port 1 (loader/debug)
- mem_we  out  1  data memory write enable
- mem_addr  out  ADDR_W  data memory address
- mem_wdata  out  DATA_W  data memory write data
- mem_rdata  in  DATA_W  data memory combinational read data
- busy  out  1  state != IDLE

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-005 Accept rule: in IDLE with at least one pN_valid, the block SHALL assert pN_ready for exactly one granted port, latch that port's we/addr/wdata and index, and go to ACCESS.
REQ-006 Ready is never asserted outside IDLE.
REQ-007 Ready depends on valid; requesters SHALL hold valid and payload stable until ready.
REQ-008 Arbitration when only one port is valid: grant that port.
REQ-009 Arbitration when both ports are valid: grant the port not recorded in last_grant, then update last_grant to the granted port.
REQ-010 last_grant resets to 1, so port 0 wins the first tie.
REQ-011 ACCESS: drive mem_addr/mem_wdata from the latched command and assert mem_we = latched we for this cycle only.
REQ-012 ACCESS: register mem_rdata for reads, or 0 for writes, into the response register; next state is RESP.
REQ-013 RESP: assert rsp_valid of the latched port only, with its rdata equal to the response register; next state is IDLE.
REQ-014 A response SHALL be issued for writes as well as reads.
REQ-015 Latency: accept at edge T, memory access in cycle T+1, rsp_valid in cycle T+2. Maximum throughput is one transaction per 3 cycles.
REQ-016 rdata of the non-responding port SHALL be held at its last value; rsp_valid of that port is 0.
REQ-017 Outside ACCESS: mem_we = 0, and mem_addr/mem_wdata hold their last value.
REQ-018 Addresses pass through unmodified, with no alignment or range checks.
REQ-019 Starvation bound: a continuously valid port is granted within 2 arbitration rounds (at most 6 cycles).

Reset
REQ-020 While rst_n = 0 at a clock edge: state = IDLE, last_grant = 1, latched command cleared to 0, response register cleared to 0.
REQ-021 Every output is 0 during and immediately after reset, including mem_we, mem_addr, mem_wdata, both readies, both rsp_valids, both rdatas, and busy.
REQ-022 Reset asserted in ACCESS or RESP SHALL abandon the transaction. No mem_we pulse and no rsp_valid is produced for it after reset.

Structure
REQ-023 Shared package dmem_arb_pkg SHALL hold:
- the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
- default ADDR_W/DATA_W constants
- port index constants PORT_CORE=0 and PORT_LOAD=1
REQ-024 Two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 with inputs req[1:0], last[0], and output gnt[1:0] (one-hot or zero). It is purely combinational; last_grant stays in dmem_arbiter.

Verification
REQ-025 Single read: p0 read, addr 0x10, mem_rdata = 0xDEADBEEF -> p0_ready at T, mem_we = 0 and mem_addr = 0x10 at T+1, p0_rsp_valid = 1 with p0_rdata = 0xDEADBEEF at T+2.
REQ-026 Single write: p1 write, addr 0x20, data 0x12345678 -> exactly one mem_we cycle with mem_addr = 0x20 and mem_wdata = 0x12345678, then p1_rsp_valid = 1 with p1_rdata = 0.
REQ-027 Tie after reset: both ports valid continuously for 4 transactions -> grant order p0, p1, p0, p1; each rsp_valid is 3 cycles apart.
REQ-028 Backpressure: p1 asserts valid during p0's ACCESS -> p1_ready stays 0 until the next IDLE, then p1 is granted; p1 payload is sampled correctly.
REQ-029 Reset mid-operation: rst_n = 0 in the ACCESS cycle of a write -> no rsp_valid afterwards, all outputs 0, and the first tie after release goes to p0.
REQ-030 Idle: no valids for 10 cycles -> busy = 0, mem_we = 0, no readies, no responses.
